hazard_flush_ctrl: RTL
======================

Name: hazard_flush_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV64 core. It generates the `flush` and hold controls consumed by the IF/ID, ID/EX and EX/MEM pipeline registers, and the PC write enable.
- Detects load-use hazards between ID and EX and stalls for a programmable number of cycles with a down-counter FSM.
- Squashes wrong-path instructions when a branch resolves taken in MEM.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- LOAD_STALL, 1, bubble cycles inserted per load-use hazard (legal 1..15).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_rs1  input  5  rs1 field of the instruction in ID
- id_rs2  input  5  rs2 field of the instruction in ID
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- idex_memread  input  1  memreadout of the ID/EX register
- idex_rd  input  5  RDout of the ID/EX register
- br_taken  input  1  branch in EX/MEM resolved taken (branch & zero)
- pc_write  output  1  PC update enable
- ifid_write  output  1  IF/ID load enable (0 = hold)
- ifid_flush  output  1  zero the IF/ID register
- idex_flush  output  1  drives the ID/EX `flush` input
- exmem_flush  output  1  zero the EX/MEM register
- stall_cnt  output  CNT_W  total stall cycles, saturating
- flush_cnt  output  CNT_W  total taken-branch flush events, saturating

Behaviour:
- Reset (rst_n low, asynchronous): state RUN; remain counter 0; stall_cnt = 0; flush_cnt = 0.
  - While rst_n is low: pc_write = 0, ifid_write = 0, ifid_flush = idex_flush = exmem_flush = 1.
  - Deassertion takes effect at the first rising clk edge.
- Hazard term: lu = idex_memread & (idex_rd != 0) & ((id_use_rs1 & idex_rd == id_rs1) | (id_use_rs2 & idex_rd == id_rs2)).
  - x0 never creates a hazard.
- All control outputs are combinational from the current state and inputs, so a hazard is acted on in the same cycle it is detected (zero-cycle latency).
- Default outputs, no event: pc_write = 1, ifid_write = 1, all flushes 0.
- FSM has two states, RUN and STALL, and a 4-bit remain counter.
- RUN with br_taken = 1 (priority over lu):
  - pc_write = 1 (PC loads the branch target); ifid_flush = idex_flush = exmem_flush = 1; ifid_write = 1.
  - flush_cnt increments; stay in RUN.
- RUN with lu = 1 and br_taken = 0:
  - pc_write = 0, ifid_write = 0, idex_flush = 1 (one bubble); stall_cnt increments.
  - If LOAD_STALL > 1: go to STALL with remain = LOAD_STALL - 1. Otherwise stay in RUN.
- STALL with br_taken = 0:
  - Same outputs as a stall (pc_write = 0, ifid_write = 0, idex_flush = 1); stall_cnt increments; remain decrements.
  - When remain == 1, go to RUN.
  - lu is ignored in STALL, because the load has already left ID/EX.
- STALL with br_taken = 1 (an older branch resolves during the stall):
  - Branch wins: branch flush outputs as in RUN, and the stalled ID instruction is squashed.
  - remain cleared; go to RUN; flush_cnt increments; stall_cnt does not increment this cycle.
- Back-to-back hazards: a new lu may be detected in the first RUN cycle after a STALL exit.
- Counters increment by 1 per qualifying cycle and saturate at 2^CNT_W - 1, never wrapping.
- Reset asserted mid-STALL returns to RUN immediately; counters and remain are cleared.

Test Plan:
- Reset: rst_n = 0 for 3 cycles, then release -> during reset pc_write = 0, all flushes = 1; after release pc_write = 1, ifid_write = 1, flushes 0, both counters 0.
- Load-use, LOAD_STALL = 1: idex_memread = 1, idex_rd = 5, id_rs1 = 5, id_use_rs1 = 1 for one cycle -> that cycle pc_write = 0, ifid_write = 0, idex_flush = 1; next cycle normal; stall_cnt = 1.
- x0 and unused operand: idex_rd = 0 = id_rs1 -> no stall. Separately, idex_rd = 7 = id_rs2 with id_use_rs2 = 0 -> no stall; stall_cnt stays 0.
- LOAD_STALL = 3: single lu pulse -> stall outputs held exactly 3 cycles, state returns to RUN; stall_cnt = 3.
- Branch during stall, LOAD_STALL = 3: br_taken = 1 in the second stall cycle -> that cycle all three flushes = 1 and pc_write = 1; next cycle normal; stall_cnt = 1, flush_cnt = 1.
- Simultaneous events and saturation, CNT_W = 4: lu and br_taken in the same cycle -> branch flush only, no stall, flush_cnt + 1. Then 20 separate branch flushes -> flush_cnt holds at 15.

Source files
------------

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard controller: load-use stall FSM, taken-branch squash and
// saturating stall/flush event counters.
module hazard_flush_ctrl #(
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             br_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     state, state_nxt;
  logic [3:0] remain, remain_nxt;
  logic       lu;
  logic       stall_inc, flush_inc;

  assign lu = idex_memread && (idex_rd != 5'd0) &&
              ((id_use_rs1 && (idex_rd == id_rs1)) ||
               (id_use_rs2 && (idex_rd == id_rs2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      remain <= '0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
    end
  end

  // Outputs are forced to the safe squash pattern for as long as reset is held.
  always_comb begin
    state_nxt   = state;
    remain_nxt  = remain;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (br_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      flush_inc   = 1'b1;
      state_nxt   = RUN;
      remain_nxt  = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
            if (LOAD_STALL > 1) begin
              state_nxt  = STALL;
              remain_nxt = 4'(LOAD_STALL - 1);
            end
          end
        end
        STALL: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
          remain_nxt = remain - 4'd1;
          if (remain == 4'd1) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
